ahb_from_adc: RTL and testbench

- AHB-Lite slave for the receive side of the RGB link: sequences a parallel 8-bit 3-channel ADC (colour photodiode front end) and returns one packed R/G/B sample to the CPU.
- Software writes START, the block converts channels 0..NUM_CH-1 in order, then latches the results into SAMPLE and sets VALID.
- Sits beside the DAC transmit peripheral on the same AHB fabric and clock.

---
 rtl/ahb_from_adc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ahb_from_adc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_from_adc.sv
// ahb_from_adc: AHB-Lite slave that sequences an 8-bit, 3-channel parallel ADC
// and returns one packed R/G/B sample through a small register map.
//   0x0 CTRL/STATUS  W: bit0 START, bit1 CLR   R: bit0 BUSY, bit1 VALID, bit2 OVR, bit3 ERR
//   0x4 SAMPLE       R: {8'b0, ch2, ch1, ch0}; a read clears VALID
//   0x8 PERIOD       only with ADC_AUTO_SAMPLE_EN (16-bit R/W), otherwise reads 0
// Optional feature macro: ADC_AUTO_SAMPLE_EN adds periodic self-triggered sampling.
// With it, CTRL write bit2 is AUTO; AUTO reads back on status bit4 because
// bit2 is already taken by OVR.
// Handshake: zero-wait-state AHB-Lite. A transfer is taken in the address
// phase when HSEL && HREADY && HTRANS[1] && HSIZE==word. Its data phase is the
// following cycle: reads are served combinationally and writes commit at the
// clock edge that ends that data phase.
module ahb_from_adc #(
  parameter int NUM_CH        = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONV_PULSE    = 2,
  parameter int RD_CYCLES     = 3,
  parameter int TIMEOUT       = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HMASTLOCK,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        ADC_CS,
  output logic        ADC_RD,
  output logic        ADC_CONVST,
  output logic [1:0]  ADC_A,
  input  logic        ADC_BUSY,
  input  logic [7:0]  ADC_DATA,
  output logic [2:0]  dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CONV    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic [23:0]   slots_q, slots_d;
  logic [23:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          err_q, err_d;
  logic          busy_s1_q, busy_s2_q;
  logic          dp_valid_q, dp_write_q;
  logic [1:0]    dp_addr_q;

  logic          accept;
  logic          wr_ctrl, rd_sample;
  logic          start_req, clr;
  logic          set_valid, set_err, set_ovr;
  logic          auto_tick;
  logic [31:0]   period_rd;
  logic          auto_rd;
  logic          fsm_busy;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 2'b00;
  assign dbg_state_o = state_q;
  assign fsm_busy    = (state_q != S_IDLE);

  // Strobes decode straight from the state register so an async reset
  // returns them to their idle (high) levels immediately.
  assign ADC_CONVST = (state_q != S_CONV);
  assign ADC_CS     = (state_q != S_READ);
  assign ADC_RD     = (state_q != S_READ);
  assign ADC_A      = ch_q;

  assign accept    = HSEL && HREADY && HTRANS[1] && (HSIZE == 3'b010);
  assign wr_ctrl   = dp_valid_q && dp_write_q && (dp_addr_q == 2'd0);
  assign rd_sample = dp_valid_q && !dp_write_q && (dp_addr_q == 2'd1);
  assign clr       = wr_ctrl && HWDATA[1];
  assign start_req = (wr_ctrl && HWDATA[0]) || auto_tick;
  assign set_ovr   = start_req && fsm_busy;

  // Address-phase capture of the accepted transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
    end else if (HREADY) begin
      dp_valid_q <= accept;
      dp_write_q <= HWRITE;
      dp_addr_q  <= HADDR[3:2];
    end
  end

  // Two-flop synchronizer for the asynchronous BUSY line.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= ADC_BUSY;
      busy_s2_q <= busy_s1_q;
    end
  end

  // Conversion sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    ch_d      = ch_q;
    slots_d   = slots_q;
    sample_d  = sample_q;
    set_valid = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_req) begin
          ch_d    = 2'd0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == CW'(CONV_PULSE - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (busy_s2_q) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          ch_d    = 2'd0;
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_LO: begin
        if (!busy_s2_q) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          ch_d    = 2'd0;
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt_q == CW'(RD_CYCLES - 1)) begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (ch_q == 2'(n)) slots_d[8*n +: 8] = ADC_DATA;
          end
          cnt_d   = '0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (ch_q == 2'(NUM_CH - 1)) begin
          // All channels move into SAMPLE together so a read never mixes runs.
          sample_d  = slots_q;
          set_valid = 1'b1;
          ch_d      = 2'd0;
          state_d   = S_IDLE;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        ch_d    = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Flag updates: a hardware set beats a clear arriving in the same cycle.
  always_comb begin
    valid_d = set_valid | (valid_q & ~(clr | rd_sample));
    ovr_d   = set_ovr   | (ovr_q   & ~clr);
    err_d   = set_err   | (err_q   & ~clr);
  end

  // Sequencer and status registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ch_q     <= 2'd0;
      slots_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      slots_q  <= slots_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      err_q    <= err_d;
    end
  end

`ifdef ADC_AUTO_SAMPLE_EN
  logic [15:0] period_q;
  logic [15:0] acnt_q;
  logic        auto_q;
  logic        wr_period;
  logic        unused_wdata;

  assign wr_period    = dp_valid_q && dp_write_q && (dp_addr_q == 2'd2);
  assign auto_tick    = auto_q && (acnt_q == period_q);
  assign period_rd    = {16'b0, period_q};
  assign auto_rd      = auto_q;
  assign unused_wdata = ^HWDATA[31:16];

  // PERIOD/AUTO registers and the free-running auto-start counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      period_q <= 16'd0;
      auto_q   <= 1'b0;
      acnt_q   <= 16'd0;
    end else begin
      if (wr_period) period_q <= HWDATA[15:0];
      if (wr_ctrl)   auto_q   <= HWDATA[2];
      if (!auto_q || (wr_ctrl && !HWDATA[2]) || auto_tick) acnt_q <= 16'd0;
      else                                                 acnt_q <= acnt_q + 16'd1;
    end
  end
`else
  logic unused_wdata;

  assign auto_tick    = 1'b0;
  assign period_rd    = 32'd0;
  assign auto_rd      = 1'b0;
  assign unused_wdata = ^HWDATA[31:2];
`endif

  // Read data mux for the data phase of an accepted read.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        2'd0:    HRDATA = {27'd0, auto_rd, err_q, ovr_q, valid_q, fsm_busy};
        2'd1:    HRDATA = {8'd0, sample_q};
        2'd2:    HRDATA = period_rd;
        default: HRDATA = 32'd0;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:4], HADDR[1:0], HBURST, HPROT, HMASTLOCK,
                           HTRANS[0], unused_wdata};

endmodule

// File: tb/tb_ahb_from_adc.sv
// Bench for ahb_from_adc: AHB driver tasks, a behavioural ADC device with a
// strobe monitor, a flag/sample reference model and an expected-sample queue.
module tb_ahb_from_adc;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, HMASTLOCK = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010, HBURST = 3'b000;
  logic [3:0]  HPROT = 4'b0011;
  logic [1:0]  HTRANS = 2'b00;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        ADC_CS, ADC_RD, ADC_CONVST;
  logic [1:0]  ADC_A;
  logic        ADC_BUSY = 1'b0;
  wire  [7:0]  ADC_DATA;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Clock and cycle counter.
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  ahb_from_adc dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE),
    .HREADY(HREADY), .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ADC_CS(ADC_CS), .ADC_RD(ADC_RD), .ADC_CONVST(ADC_CONVST), .ADC_A(ADC_A),
    .ADC_BUSY(ADC_BUSY), .ADC_DATA(ADC_DATA), .dbg_state_o(dbg_state)
  );

  // ---------------- ADC device model and strobe monitor ----------------
  logic [7:0]  chan_val [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int          busy_len = 10;
  bit          adc_respond = 1'b1;
  int          busy_left = 0;
  int          conv_run = 0;
  int          rd_run = 0;
  logic [31:0] conv_len_q [$];
  logic [31:0] conv_ch_q  [$];
  logic [31:0] rd_len_q   [$];

  assign ADC_DATA = chan_val[ADC_A];

  // BUSY rises when CONVST returns high and stays up busy_len cycles.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      busy_left = 0;
      conv_run  = 0;
      rd_run    = 0;
    end else begin
      if (ADC_CONVST && conv_run > 0) begin
        conv_len_q.push_back(32'(conv_run));
        conv_ch_q.push_back(32'(ADC_A));
        conv_run = 0;
        if (adc_respond) busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (!ADC_CONVST) conv_run++;
      if (!ADC_RD) rd_run++;
      else if (rd_run > 0) begin
        rd_len_q.push_back(32'(rd_run));
        rd_run = 0;
      end
    end
    ADC_BUSY = (busy_left > 0);
  end

  // ---------------- reference model ----------------
  bit          m_valid = 0, m_ovr = 0, m_err = 0;
  logic [31:0] m_sample = 0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] exp_status(input bit busy);
    return {28'd0, m_err, m_ovr, m_valid, busy};
  endfunction

  function automatic logic [31:0] pack_sample();
    return {8'd0, chan_val[2], chan_val[1], chan_val[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- AHB driver tasks ----------------
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = sz;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010;
    d = HRDATA;
  endtask

  // Two pipelined word writes to CTRL, the second in the first's data phase.
  task automatic ahb_write_b2b(input logic [31:0] d0, input logic [31:0] d1);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'b010;
    @(negedge HCLK);
    HWDATA = d0;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d1;
  endtask

  // Poll status until BUSY drops, bounded by a cycle budget.
  task automatic wait_done(input string tag, input int budget,
                           output logic [31:0] st, output int took);
    int t0;
    t0 = cyc;
    st = 32'hFFFF_FFFF;
    while ((cyc - t0) < budget) begin
      ahb_read(32'h0, 3'b010, st);
      if (st[0] == 1'b0) break;
    end
    took = cyc - t0;
    check({tag, "_idle"}, {31'd0, st[0]}, 32'd0);
  endtask

  task automatic clear_monitor();
    conv_len_q.delete();
    conv_ch_q.delete();
    rd_len_q.delete();
  endtask

  task automatic check_strobes(input string tag, input int nch);
    check({tag, "_nconv"}, 32'(conv_len_q.size()), 32'(nch));
    check({tag, "_nrd"},   32'(rd_len_q.size()),   32'(nch));
    for (int i = 0; i < nch && i < conv_len_q.size() && i < rd_len_q.size(); i++) begin
      check($sformatf("%s_convlen%0d", tag, i), conv_len_q[i], 32'd2);
      check($sformatf("%s_convch%0d", tag, i),  conv_ch_q[i],  32'(i));
      check($sformatf("%s_rdlen%0d", tag, i),   rd_len_q[i],   32'd3);
    end
  endtask

  task automatic randomize_channels();
    for (int i = 0; i < 3; i++) chan_val[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] prior;
    int          took;
    int          guard;

    // Reset
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check("rst_cs",     {31'd0, ADC_CS},     32'd1);
    check("rst_rd",     {31'd0, ADC_RD},     32'd1);
    check("rst_convst", {31'd0, ADC_CONVST}, 32'd1);
    check("rst_a",      {30'd0, ADC_A},      32'd0);
    check("rst_hrdata", HRDATA,              32'd0);
    HRESETn = 1'b1;
    check("hreadyout",  {31'd0, HREADYOUT},  32'd1);
    check("hresp",      {30'd0, HRESP},      32'd0);
    ahb_read(32'h0, 3'b010, rd); check("rst_status", rd, exp_status(0));
    ahb_read(32'h4, 3'b010, rd); check("rst_sample", rd, 32'd0);

    // A byte-sized START has no effect
    ahb_write(32'h0, 32'h1, 3'b000);
    ahb_read(32'h0, 3'b010, rd); check("byte_start_ignored", rd, exp_status(0));

    // Directed conversion with fixed channel values
    chan_val[0] = 8'h11; chan_val[1] = 8'h22; chan_val[2] = 8'h33;
    busy_len = 10; adc_respond = 1'b1;
    clear_monitor();
    ahb_write(32'h0, 32'h1, 3'b010);
    exp_q.push_back(pack_sample());
    wait_done("conv1", 2000, rd, took);
    m_valid = 1; m_sample = exp_q.pop_front();
    check("conv1_status", rd, exp_status(0));
    check_strobes("conv1", 3);
    ahb_read(32'h4, 3'b000, rd); check("byte_read_zero", rd, 32'd0);
    ahb_read(32'h0, 3'b010, rd); check("byte_read_keeps_valid", rd, exp_status(0));
    ahb_read(32'h4, 3'b010, rd); check("conv1_sample", rd, m_sample);
    m_valid = 0;
    ahb_read(32'h0, 3'b010, rd); check("read_clears_valid", rd, exp_status(0));
    ahb_write(32'h4, 32'hDEAD_BEEF, 3'b010);
    ahb_read(32'h4, 3'b010, rd); check("sample_write_ignored", rd, m_sample);
    ahb_read(32'h8, 3'b010, rd); check("reg8_zero", rd, 32'd0);
    ahb_read(32'hC, 3'b010, rd); check("regC_zero", rd, 32'd0);

    // Back-to-back START: one conversion, OVR set
    randomize_channels();
    clear_monitor();
    ahb_write_b2b(32'h1, 32'h1);
    exp_q.push_back(pack_sample());
    m_ovr = 1;
    ahb_read(32'h0, 3'b010, rd); check("b2b_busy_status", rd, exp_status(1));
    wait_done("b2b", 2000, rd, took);
    m_valid = 1; m_sample = exp_q.pop_front();
    check("b2b_done_status", rd, exp_status(0));
    check_strobes("b2b", 3);
    ahb_read(32'h4, 3'b010, rd); check("b2b_sample", rd, m_sample);
    m_valid = 0;

    // CLR and START together: flags clear and a conversion begins
    randomize_channels();
    ahb_write(32'h0, 32'h3, 3'b010);
    exp_q.push_back(pack_sample());
    m_ovr = 0;
    ahb_read(32'h0, 3'b010, rd); check("clr_start_status", rd, exp_status(1));
    wait_done("clr_start", 2000, rd, took);
    m_valid = 1; m_sample = exp_q.pop_front();
    check("clr_start_done", rd, exp_status(0));
    ahb_read(32'h4, 3'b010, rd); check("clr_start_sample", rd, m_sample);
    m_valid = 0;

    // Randomized conversions with varying BUSY lengths
    for (int it = 0; it < 6; it++) begin
      randomize_channels();
      busy_len = $urandom_range(1, 25);
      clear_monitor();
      ahb_write(32'h0, 32'h1, 3'b010);
      exp_q.push_back(pack_sample());
      wait_done($sformatf("rnd%0d", it), 2000, rd, took);
      m_valid = 1; m_sample = exp_q.pop_front();
      check($sformatf("rnd%0d_status", it), rd, exp_status(0));
      check_strobes($sformatf("rnd%0d", it), 3);
      if ($urandom_range(0, 1) == 1) begin
        ahb_write(32'h0, 32'h2, 3'b010);
        m_valid = 0;
        ahb_read(32'h0, 3'b010, rd); check($sformatf("rnd%0d_clr", it), rd, exp_status(0));
      end
      ahb_read(32'h4, 3'b010, rd); check($sformatf("rnd%0d_sample", it), rd, m_sample);
      m_valid = 0;
    end

    // ADC never raises BUSY: timeout sets ERR, SAMPLE is kept
    prior = m_sample;
    adc_respond = 1'b0;
    randomize_channels();
    ahb_write(32'h0, 32'h1, 3'b010);
    wait_done("tmo", 3000, rd, took);
    m_err = 1;
    check("tmo_status", rd, exp_status(0));
    check("tmo_window", {31'd0, (took >= 1024 && took <= 1080)}, 32'd1);
    check("tmo_convst", {31'd0, ADC_CONVST}, 32'd1);
    check("tmo_cs",     {31'd0, ADC_CS},     32'd1);
    ahb_read(32'h4, 3'b010, rd); check("tmo_sample_kept", rd, prior);
    ahb_write(32'h0, 32'h2, 3'b010);
    m_err = 0;
    ahb_read(32'h0, 3'b010, rd); check("tmo_clr", rd, exp_status(0));
    adc_respond = 1'b1;

    // Asynchronous reset while the ADC read strobes are low
    randomize_channels();
    busy_len = 5;
    ahb_write(32'h0, 32'h1, 3'b010);
    guard = 0;
    while (ADC_RD !== 1'b0 && guard < 500) begin
      @(negedge HCLK);
      guard++;
    end
    check("rst_mid_found_read", {31'd0, ADC_RD}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_cs",     {31'd0, ADC_CS},     32'd1);
    check("rst_mid_rd",     {31'd0, ADC_RD},     32'd1);
    check("rst_mid_convst", {31'd0, ADC_CONVST}, 32'd1);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    m_valid = 0; m_ovr = 0; m_err = 0; m_sample = 0;
    exp_q.delete();
    ahb_read(32'h0, 3'b010, rd); check("rst_mid_status", rd, exp_status(0));
    ahb_read(32'h4, 3'b010, rd); check("rst_mid_sample", rd, m_sample);

    repeat (4) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "global timeout");
  end

endmodule
